// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM core: counting mode and count direction.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler plus edge (up) / centre (up-down) duty counter.
// Latency: count, tick and boundary are valid in the cycle they are used; no backpressure.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int R = 10,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [P-1:0] dvsr,
  input  pwm_mode_e    mode_act,
  output logic [R-1:0] count,
  output logic         tick,
  output logic         boundary
);

  localparam logic [R-1:0] CNT_MAX = '1;

  logic [P-1:0] q_q, q_d;
  logic [R-1:0] cnt_q, cnt_d, cnt_step;
  pwm_dir_e     dir_q, dir_d;

  assign tick = en && (q_q == dvsr);

  // Direction is already DN while sitting at the top, so +1 never wraps in centre mode.
  always_comb begin
    cnt_step = cnt_q + R'(1);
    if (mode_act == PWM_CENTER && dir_q == DIR_DN) cnt_step = cnt_q - R'(1);
  end

  assign boundary = tick && (cnt_step == '0);

  always_comb begin
    q_d   = q_q + P'(1);
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      q_d   = '0;
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      q_d   = '0;
      cnt_d = cnt_step;
      if (boundary) dir_d = DIR_UP;
      else if (mode_act == PWM_CENTER && cnt_step == CNT_MAX) dir_d = DIR_DN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with double-buffered duty registers swapped at each period boundary.
// Latency: pwm_out and period_tick are registered, 1 clk after the count change; no backpressure.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int W = 6,
  parameter int R = 10,
  parameter int P = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [P-1:0]         dvsr,
  input  logic                 mode,
  input  logic                 wr_en,
  input  logic [$clog2(W)-1:0] wr_ch,
  input  logic [R:0]           wr_duty,
  output logic [W-1:0]         pwm_out,
  output logic                 period_tick
);

  localparam int CW = $clog2(W);

  logic [R-1:0]      cnt;
  logic              tick;
  logic              boundary;
  logic              load_act;
  pwm_mode_e         mode_act_q, mode_act_d;
  logic [W-1:0]      pwm_q, pwm_d;
  logic              tick_q;
  logic [W-1:0][R:0] duty_buf;
  logic [W-1:0][R:0] duty_act;

  pwm_timebase #(
    .R(R),
    .P(P)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dvsr     (dvsr),
    .mode_act (mode_act_q),
    .count    (cnt),
    .tick     (tick),
    .boundary (boundary)
  );

  // While disabled the active set tracks the staged set so a restart uses fresh values.
  assign load_act   = !en || (tick && boundary);
  assign mode_act_d = load_act ? pwm_mode_e'(mode) : mode_act_q;

  for (genvar i = 0; i < W; i++) begin : g_ch
    logic [R:0] buf_q, act_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        buf_q <= '0;
        act_q <= '0;
      end else begin
        if (wr_en && wr_ch == CW'(i)) buf_q <= wr_duty;
        if (load_act) act_q <= duty_buf[i];
      end
    end

    assign duty_buf[i] = buf_q;
    assign duty_act[i] = act_q;
    assign pwm_d[i]    = en && ({1'b0, cnt} < duty_act[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_act_q <= PWM_EDGE;
      pwm_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      mode_act_q <= mode_act_d;
      pwm_q      <= pwm_d;
      tick_q     <= boundary;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi at R=4, P=4; three channels so wr_ch can encode an out-of-range index.
module tb_pwm_multi;

  localparam int W   = 3;
  localparam int R   = 4;
  localparam int P   = 4;
  localparam int LIM = 200;

  logic         clk = 1'b0;
  logic         reset, en, mode, wr_en;
  logic [P-1:0] dvsr;
  logic [1:0]   wr_ch;
  logic [R:0]   wr_duty;
  logic [W-1:0] pwm_out;
  logic         period_tick;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int dvsr;
    int mode;
    int d0;
    int d1;
    int per;
    int hi0;
    int hi1;
  } vec_t;

  vec_t tbl[6];

  pwm_multi #(.W(W), .R(R), .P(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .dvsr        (dvsr),
    .mode        (mode),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = 5'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Clocks from now until period_tick is seen (capped at LIM).
  task automatic wait_tick(output int k);
    k = 0;
    while (k < LIM) begin
      @(negedge clk);
      k++;
      if (period_tick) break;
    end
  endtask

  // Starting on a period_tick sample, walk one full period; optionally write at clock wr_at.
  task automatic measure(input int wr_at, input int wch, input int wd,
                         output int per, output int hi0, output int hi1);
    per = 0;
    hi0 = 0;
    hi1 = 0;
    while (per < LIM) begin
      @(negedge clk);
      wr_en = 1'b0;
      per++;
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (per == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = 2'(wch);
        wr_duty = 5'(wd);
      end
      if (period_tick) break;
    end
    wr_en = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int k, per, h0, h1;
    @(negedge clk);
    dvsr = 4'(v.dvsr);
    mode = v.mode[0];
    wr(0, v.d0);
    wr(1, v.d1);
    @(negedge clk);
    en = 1'b1;
    wait_tick(k);
    chk($sformatf("v%0d_first_tick", n), k, v.per);
    measure(-1, 0, 0, per, h0, h1);
    chk($sformatf("v%0d_period", n), per, v.per);
    chk($sformatf("v%0d_hi0", n), h0, v.hi0);
    chk($sformatf("v%0d_hi1", n), h1, v.hi1);
    en = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_off_pwm", n), int'(pwm_out), 0);
  endtask

  int k, per, h0, h1;

  initial begin
    //        dvsr mode d0  d1  per hi0 hi1
    tbl[0] = '{0,  0,   5,  0,  16, 5,  0};
    tbl[1] = '{0,  0,   15, 16, 16, 15, 16};
    tbl[2] = '{0,  0,   20, 1,  16, 16, 1};
    tbl[3] = '{0,  1,   4,  15, 30, 7,  29};
    tbl[4] = '{3,  0,   2,  31, 64, 8,  64};
    tbl[5] = '{1,  1,   1,  0,  60, 2,  0};

    reset   = 1'b1;
    en      = 1'b0;
    mode    = 1'b0;
    wr_en   = 1'b0;
    dvsr    = '0;
    wr_ch   = '0;
    wr_duty = '0;
    repeat (2) @(negedge clk);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_tick", int'(period_tick), 0);
    chk("reset_cnt", int'(dut.cnt), 0);
    reset = 1'b0;

    for (int n = 0; n < 6; n++) run_vec(n, tbl[n]);

    // Running edge mode: ch0=5, ch1=0.
    @(negedge clk);
    dvsr = '0;
    mode = 1'b0;
    wr(0, 5);
    wr(1, 0);
    @(negedge clk);
    en = 1'b1;
    wait_tick(k);
    chk("seq_first_tick", k, 16);

    // ch1 full-on then full-off, each only from the following boundary.
    measure(3, 1, 20, per, h0, h1);
    chk("full_on_staged_hi1", h1, 0);
    chk("full_on_staged_hi0", h0, 5);
    measure(3, 1, 0, per, h0, h1);
    chk("full_on_hi1", h1, 16);
    measure(-1, 0, 0, per, h0, h1);
    chk("full_off_hi1", h1, 0);

    // Mid-period write at count 7.
    measure(7, 0, 9, per, h0, h1);
    chk("midwr_cur_hi0", h0, 5);
    measure(-1, 0, 0, per, h0, h1);
    chk("midwr_next_hi0", h0, 9);
    chk("midwr_period", per, 16);

    // Write landing on the boundary clock waits one more period.
    measure(15, 0, 3, per, h0, h1);
    chk("bndwr_cur_hi0", h0, 9);
    measure(-1, 0, 0, per, h0, h1);
    chk("bndwr_next_hi0", h0, 9);
    measure(-1, 0, 0, per, h0, h1);
    chk("bndwr_after_hi0", h0, 3);

    // Reset while ch0 is high.
    @(negedge clk);
    chk("rst_pre_hi0", int'(pwm_out[0]), 1);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_cnt", int'(dut.cnt), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_buf0", int'(dut.duty_buf[0]), 0);
    chk("rst_act0", int'(dut.duty_act[0]), 0);
    reset = 1'b0;

    wr(3, 7);
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("badch_buf%0d", i), int'(dut.duty_buf[i]), 0);
      chk($sformatf("badch_act%0d", i), int'(dut.duty_act[i]), 0);
    end
    wr(2, 7);
    chk("ch2_buf", int'(dut.duty_buf[2]), 7);
    @(negedge clk);
    chk("ch2_act_en_low", int'(dut.duty_act[2]), 7);
    chk("en_low_pwm", int'(pwm_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
